// File: rtl/pattern_sender_pkg.sv
// Shared definitions for the pattern-detect link: default pattern, frame length, timing and FSM states.
// Imported by the transmitter; the detector side uses the same constants.
package pattern_sender_pkg;

  localparam int          DEF_PATTERN_LEN = 64;
  localparam logic [63:0] DEF_PATTERN     = 64'h574A_B5DE_ED51_7984;
  localparam int          DEF_HALF_PERIOD = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    TAIL = 2'd3
  } state_t;

endpackage

// File: rtl/pattern_phase_timer.sv
// Half-period down-counter: phase_end pulses on the last cycle of each HALF_PERIOD-long phase.
// load restarts a full phase on the next cycle; the counter reloads itself at every phase end.
module pattern_phase_timer #(
  parameter int HALF_PERIOD = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic phase_end
);

  localparam int             W      = $clog2(HALF_PERIOD);
  localparam logic [W-1:0]   RELOAD = W'(HALF_PERIOD - 1);

  logic [W-1:0] cnt;

  assign phase_end = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= RELOAD;
    end else if (load || phase_end) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/pattern_sender.sv
// Serial pattern transmitter: shifts PATTERN out LSB-first with a slow framed clock, optional one-bit corruption.
// All outputs registered; a start while busy (including the done cycle) is dropped, never queued.
module pattern_sender
  import pattern_sender_pkg::*;
#(
  parameter int                     PATTERN_LEN = DEF_PATTERN_LEN,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = DEF_PATTERN,
  parameter int                     HALF_PERIOD = DEF_HALF_PERIOD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       injectErr,
  input  logic [7:0] errBit,
  output logic       busy,
  output logic       done,
  output logic       dataOut,
  output logic       dataClkOut,
  output logic       dataEnOut
);

  localparam logic [7:0]             LAST_BIT = 8'(PATTERN_LEN - 1);
  localparam logic [PATTERN_LEN-1:0] ONE_HOT0 = PATTERN_LEN'(1);

  state_t                 state_q, state_d;
  logic [PATTERN_LEN-1:0] shreg_q, shreg_d;
  logic [7:0]             bitcnt_q, bitcnt_d;
  logic                   busy_d, done_d, dout_d, dclk_d, den_d;
  logic                   accept, phase_end;
  logic [PATTERN_LEN-1:0] err_mask, frame_word;

  // busy stays high through the done cycle, so this also rejects a start coinciding with done.
  assign accept     = (state_q == IDLE) && start && !busy;
  assign err_mask   = (injectErr && (32'(errBit) < PATTERN_LEN)) ? (ONE_HOT0 << errBit) : '0;
  assign frame_word = PATTERN ^ err_mask;

  pattern_phase_timer #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .phase_end (phase_end)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    busy_d   = busy;
    done_d   = 1'b0;
    dout_d   = dataOut;
    dclk_d   = dataClkOut;
    den_d    = dataEnOut;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        den_d  = 1'b1;
        dclk_d = 1'b0;
        dout_d = 1'b0;
        if (accept) begin
          state_d  = LOW;
          shreg_d  = frame_word;
          bitcnt_d = '0;
          den_d    = 1'b0;
          dout_d   = frame_word[0];
          busy_d   = 1'b1;
        end
      end
      LOW: begin
        if (phase_end) begin
          state_d = HIGH;
          dclk_d  = 1'b1;
        end
      end
      HIGH: begin
        // Data only moves together with the falling serial clock.
        if (phase_end) begin
          dclk_d = 1'b0;
          if (bitcnt_q == LAST_BIT) begin
            state_d = TAIL;
            dout_d  = 1'b0;
          end else begin
            state_d  = LOW;
            shreg_d  = shreg_q >> 1;
            bitcnt_d = bitcnt_q + 8'd1;
            dout_d   = shreg_q[1];
          end
        end
      end
      TAIL: begin
        if (phase_end) begin
          state_d = IDLE;
          den_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dataOut    <= 1'b0;
      dataClkOut <= 1'b0;
      dataEnOut  <= 1'b1;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      busy       <= busy_d;
      done       <= done_d;
      dataOut    <= dout_d;
      dataClkOut <= dclk_d;
      dataEnOut  <= den_d;
    end
  end

endmodule

// File: tb/tb_pattern_sender.sv
// Bench for pattern_sender: table vectors, random corruption frames against a word-level model, corner sequences.
module tb_pattern_sender;

  localparam int          LEN   = 64;
  localparam int          HP    = 4;
  localparam logic [63:0] PAT   = 64'h574A_B5DE_ED51_7984;
  localparam int          FRAME = (2 * LEN + 1) * HP;

  logic       clk = 1'b0;
  logic       rst, start, injectErr;
  logic [7:0] errBit;
  logic       busy, done, dataOut, dataClkOut, dataEnOut;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pattern_sender #(
    .PATTERN_LEN (LEN),
    .PATTERN     (PAT),
    .HALF_PERIOD (HP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .injectErr  (injectErr),
    .errBit     (errBit),
    .busy       (busy),
    .done       (done),
    .dataOut    (dataOut),
    .dataClkOut (dataClkOut),
    .dataEnOut  (dataEnOut)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Word-level model: the frame is the pattern with at most one bit flipped.
  function automatic logic [63:0] model_word(input bit inj, input int eb);
    logic [63:0] w;
    w = PAT;
    if (inj && eb < LEN) w = w ^ (64'd1 << eb);
    return w;
  endfunction

  // Data must never move while the serial clock is high.
  bit prev_c = 1'b0;
  bit prev_d = 1'b0;
  always @(negedge clk) begin
    if (prev_c && dataClkOut) begin
      checks++;
      if (dataOut !== prev_d) begin
        errors++;
        $display("FAIL data_stable_high: got %0b expected %0b", dataOut, prev_d);
      end
    end
    prev_c = dataClkOut;
    prev_d = dataOut;
  end

  // Called just after a negedge; start is sampled on the following posedge.
  task automatic do_frame(input string tag, input bit inj, input logic [7:0] eb,
                          input logic [63:0] exp, input int extra_at, input bit start_on_done);
    logic [63:0] cap;
    int edges, en_low, done_at, n;
    bit pclk, busy1;
    cap = '0; edges = 0; en_low = 0; done_at = -1; n = 0; pclk = 1'b0; busy1 = 1'b0;
    start = 1'b1; injectErr = inj; errBit = eb;
    while (done_at < 0 && n < FRAME + 20) begin
      @(negedge clk);
      n++;
      start = (n == extra_at);
      if (n == 1) busy1 = busy;
      if (!dataEnOut) en_low++;
      if (dataClkOut && !pclk) begin
        if (edges < LEN) cap[edges] = dataOut;
        edges++;
      end
      pclk = dataClkOut;
      if (done) done_at = n;
    end
    start = 1'b0; injectErr = 1'b0;
    chk({tag, "_busy_first"}, 64'(busy1), 64'd1);
    chk({tag, "_bits"}, cap, exp);
    chk({tag, "_rising_edges"}, 64'(edges), 64'(LEN));
    chk({tag, "_en_low_cycles"}, 64'(en_low), 64'(FRAME));
    chk({tag, "_done_at"}, 64'(done_at), 64'(FRAME + 1));
    if (start_on_done) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_start_in_done_ignored"}, {61'd0, dataEnOut, busy, done}, 64'b100);
    end
  endtask

  typedef struct {
    bit          inj;
    logic [7:0]  eb;
    int          flip;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int   rises, k, ndone;
    bit   pc;
    vecs = '{'{1'b0, 8'd0,   -1},
             '{1'b1, 8'd5,    5},
             '{1'b1, 8'd200, -1},
             '{1'b1, 8'd0,    0},
             '{1'b1, 8'd63,  63},
             '{1'b1, 8'd64,  -1}};

    rst = 1'b1; start = 1'b0; injectErr = 1'b0; errBit = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_en", 64'(dataEnOut), 64'd1);
    chk("rst_clk", 64'(dataClkOut), 64'd0);
    chk("rst_data", 64'(dataOut), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      logic [63:0] exp;
      exp = PAT;
      if (vecs[i].flip >= 0) exp = exp ^ (64'd1 << vecs[i].flip);
      @(negedge clk);
      do_frame($sformatf("vec%0d", i), vecs[i].inj, vecs[i].eb, exp, -1, 1'b0);
    end

    // Starts mid-frame and in the done cycle are dropped; the very next cycle is accepted.
    @(negedge clk);
    do_frame("ignore", 1'b0, 8'd0, PAT, 10, 1'b1);
    do_frame("back2back", 1'b1, 8'd17, model_word(1'b1, 17), -1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      bit   inj;
      int   eb;
      inj = 1'($urandom_range(0, 1));
      eb  = int'($urandom_range(0, 255));
      @(negedge clk);
      do_frame($sformatf("rnd%0d", r), inj, 8'(eb), model_word(inj, eb), -1, 1'b0);
    end

    // Reset while bit 30 is on the high phase of its serial clock.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rises = 0; k = 0; pc = 1'b0;
    while (rises < 31 && k < FRAME) begin
      @(negedge clk);
      k++;
      if (dataClkOut && !pc) rises++;
      pc = dataClkOut;
    end
    chk("mid_reach_bit30", 64'(rises), 64'd31);
    chk("mid_clk_high", 64'(dataClkOut), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_en", 64'(dataEnOut), 64'd1);
    chk("mid_rst_clk", 64'(dataClkOut), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_data", 64'(dataOut), 64'd0);
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      if (done || !dataEnOut) ndone++;
      @(negedge clk);
    end
    chk("mid_rst_no_done", 64'(ndone), 64'd0);
    do_frame("after_rst", 1'b0, 8'd0, PAT, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
